// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register addresses, bit positions and FSM states for the UART bridge
package uart_pkg;

  // CPU-facing register map of the bridge
  localparam logic [1:0] CPU_TXD  = 2'd0;
  localparam logic [1:0] CPU_RXD  = 2'd1;
  localparam logic [1:0] CPU_BAUD = 2'd2;
  localparam logic [1:0] CPU_STAT = 2'd3;

  // simple_uart register map
  localparam logic [1:0] U_ODR = 2'd0;
  localparam logic [1:0] U_IDR = 2'd1;
  localparam logic [1:0] U_BSR = 2'd2;
  localparam logic [1:0] U_SR  = 2'd3;

  // simple_uart SR bit positions
  localparam int SR_BUSY = 0;
  localparam int SR_RX   = 1;
  localparam int SR_FE   = 2;

  // Bridge status word bit positions
  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_NEMPTY = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_RX_OVF    = 4;
  localparam int ST_TX_OVF    = 5;
  localparam int ST_BUSY      = 6;
  localparam int ST_TX_CNT    = 8;
  localparam int ST_RX_CNT    = 16;

  localparam logic [15:0] BAUD_RST = 16'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BSR,
    S_SR_REQ,
    S_SR_EVAL,
    S_IDR_REQ,
    S_IDR_EVAL,
    S_CLR,
    S_ODR
  } state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with occupancy count, drops pushes when full
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  // Full is judged on the current count, so a push into a full FIFO is dropped even when a pop happens alongside it
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  // Storage array; contents need no reset because the count guards every read
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers wrap modulo DEPTH; count tracks simultaneous push and pop
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// rtl/uart_fifo_bridge.sv - buffered CPU front-end that polls and services a simple_uart
module uart_fifo_bridge
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sel_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        we_i,
  output logic        u_sel_o,
  output logic [1:0]  u_addr_o,
  output logic [31:0] u_data_o,
  output logic        u_we_o,
  input  logic [31:0] u_data_i,
  output logic        irq_o
);

  state_e      state_q, state_d;
  logic [15:0] baud_q;
  logic        bsr_pend_q, rx_ovf_q, tx_ovf_q, busy_q, sr_fe_q;
  logic [31:0] data_q, status;

  logic        cpu_wr, cpu_rd;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  tx_head;
  logic [AW:0] tx_cnt;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [8:0]  rx_head, rx_wdata;
  logic [AW:0] rx_cnt;
  logic        unused_bits;

  // Upper bits of the bus words carry no information for this bridge
  assign unused_bits = ^{u_data_i[31:8], data_i[31:16]};

  assign cpu_wr   = sel_i && we_i;
  assign cpu_rd   = sel_i && !we_i;
  assign tx_push  = cpu_wr && (addr_i == CPU_TXD);
  assign rx_pop   = cpu_rd && (addr_i == CPU_RXD) && !rx_empty;
  assign rx_wdata = {sr_fe_q, u_data_i[7:0]};
  assign data_o   = data_q;
  assign irq_o    = !rx_empty || rx_ovf_q;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tx_push),
    .wdata_i (data_i[7:0]),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_cnt)
  );

  uart_sync_fifo #(.WIDTH(9), .DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rx_push),
    .wdata_i (rx_wdata),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_cnt)
  );

  // Assemble the CPU-visible status word
  always_comb begin
    status = '0;
    status[ST_TX_FULL]   = tx_full;
    status[ST_TX_EMPTY]  = tx_empty;
    status[ST_RX_NEMPTY] = !rx_empty;
    status[ST_RX_FULL]   = rx_full;
    status[ST_RX_OVF]    = rx_ovf_q;
    status[ST_TX_OVF]    = tx_ovf_q;
    status[ST_BUSY]      = busy_q;
    status[ST_TX_CNT +: AW+1] = tx_cnt;
    status[ST_RX_CNT +: AW+1] = rx_cnt;
  end

  // Poller next state and UART bus drive; the bus is idle outside request and write states
  always_comb begin
    state_d  = state_q;
    u_sel_o  = 1'b0;
    u_we_o   = 1'b0;
    u_addr_o = '0;
    u_data_o = '0;
    tx_pop   = 1'b0;
    rx_push  = 1'b0;
    case (state_q)
      S_IDLE:     state_d = bsr_pend_q ? S_BSR : S_SR_REQ;
      S_BSR: begin
        u_sel_o  = 1'b1;
        u_we_o   = 1'b1;
        u_addr_o = U_BSR;
        u_data_o = {16'd0, baud_q};
        state_d  = S_IDLE;
      end
      S_SR_REQ: begin
        u_sel_o  = 1'b1;
        u_addr_o = U_SR;
        state_d  = S_SR_EVAL;
      end
      S_SR_EVAL: begin
        // Receive is serviced ahead of transmit so incoming bytes are not lost
        if (u_data_i[SR_RX])                     state_d = S_IDR_REQ;
        else if (!u_data_i[SR_BUSY] && !tx_empty) state_d = S_ODR;
        else                                      state_d = S_IDLE;
      end
      S_IDR_REQ: begin
        u_sel_o  = 1'b1;
        u_addr_o = U_IDR;
        state_d  = S_IDR_EVAL;
      end
      S_IDR_EVAL: begin
        rx_push = 1'b1;
        state_d = S_CLR;
      end
      S_CLR: begin
        // Returning through IDLE gives the UART's delayed clear time to land before the next SR read
        u_sel_o  = 1'b1;
        u_we_o   = 1'b1;
        u_addr_o = U_SR;
        state_d  = S_IDLE;
      end
      S_ODR: begin
        u_sel_o  = 1'b1;
        u_we_o   = 1'b1;
        u_addr_o = U_ODR;
        u_data_o = {24'd0, tx_head};
        tx_pop   = 1'b1;
        state_d  = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // Poller state register plus SR fields captured when the status read returns
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      sr_fe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_SR_EVAL) begin
        busy_q  <= u_data_i[SR_BUSY];
        sr_fe_q <= u_data_i[SR_FE];
      end
    end
  end

  // Sticky overflow flags, baud shadow and its pending-write marker; hardware set beats CPU clear
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
      baud_q     <= BAUD_RST;
      bsr_pend_q <= 1'b0;
    end else begin
      if (tx_push && tx_full)                                   tx_ovf_q <= 1'b1;
      else if (cpu_wr && (addr_i == CPU_STAT) && data_i[ST_TX_OVF]) tx_ovf_q <= 1'b0;
      if (rx_push && rx_full)                                   rx_ovf_q <= 1'b1;
      else if (cpu_wr && (addr_i == CPU_STAT) && data_i[ST_RX_OVF]) rx_ovf_q <= 1'b0;
      if (cpu_wr && (addr_i == CPU_BAUD)) begin
        baud_q     <= data_i[15:0];
        bsr_pend_q <= 1'b1;
      end else if (state_q == S_BSR) begin
        bsr_pend_q <= 1'b0;
      end
    end
  end

  // Registered CPU read data; TX-address reads and writes leave it untouched
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q <= '0;
    end else if (cpu_rd) begin
      case (addr_i)
        CPU_RXD:  data_q <= rx_empty ? 32'd0 : {23'd0, rx_head};
        CPU_BAUD: data_q <= {16'd0, baud_q};
        CPU_STAT: data_q <= status;
        default:  data_q <= data_q;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb/tb_uart_fifo_bridge.sv - scoreboard bench with a behavioural simple_uart register model
module tb_uart_fifo_bridge;

  logic        clk_i  = 1'b0;
  logic        rst_i  = 1'b0;
  logic        sel_i  = 1'b0;
  logic [1:0]  addr_i = 2'd0;
  logic [31:0] data_i = 32'd0;
  logic        we_i   = 1'b0;
  logic [31:0] data_o;
  logic        u_sel_o;
  logic [1:0]  u_addr_o;
  logic [31:0] u_data_o;
  logic        u_we_o;
  logic [31:0] u_data_i;
  logic        irq_o;

  uart_fifo_bridge #(.DEPTH(16), .AW(4)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sel_i    (sel_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .data_o   (data_o),
    .we_i     (we_i),
    .u_sel_o  (u_sel_o),
    .u_addr_o (u_addr_o),
    .u_data_o (u_data_o),
    .u_we_o   (u_we_o),
    .u_data_i (u_data_i),
    .irq_o    (irq_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_wr_cyc = 0;

  logic [31:0] exp_rd [$];
  logic [7:0]  exp_tx [$];
  logic [15:0] exp_bsr [$];
  logic [8:0]  rx_src [$];

  logic       m_busy, m_rx, m_fe, m_clr;
  logic [3:0] m_cnt;
  logic [7:0] m_byte;
  logic       force_busy = 1'b0;
  logic       rd_pend = 1'b0;
  logic       idr_open = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_extra(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%08h with nothing expected", name, act);
  endtask

  // UART register model: SR {fe, rx, busy}, IDR byte, busy timer after ODR, clear of rx one cycle after CLR
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_busy <= 1'b0; m_rx <= 1'b0; m_fe <= 1'b0; m_clr <= 1'b0;
      m_cnt <= 4'd0; m_byte <= 8'd0; u_data_i <= 32'd0;
    end else begin
      u_data_i <= 32'd0;
      if (u_sel_o && !u_we_o) begin
        if (u_addr_o == 2'd3)      u_data_i <= {29'd0, m_fe, m_rx, m_busy | force_busy};
        else if (u_addr_o == 2'd1) u_data_i <= {24'd0, m_byte};
      end
      if (m_cnt != 4'd0) m_cnt <= m_cnt - 4'd1;
      else               m_busy <= 1'b0;
      if (u_sel_o && u_we_o && u_addr_o == 2'd0) begin
        m_busy <= 1'b1;
        m_cnt  <= 4'd10;
      end
      m_clr <= u_sel_o && u_we_o && u_addr_o == 2'd3;
      if (m_clr) m_rx <= 1'b0;
      else if (!m_rx && rx_src.size() != 0) begin
        m_rx   <= 1'b1;
        m_fe   <= rx_src[0][8];
        m_byte <= rx_src[0][7:0];
        void'(rx_src.pop_front());
      end
    end
  end

  always @(posedge clk_i) begin
    cyc     <= cyc + 1;
    rd_pend <= rst_i && sel_i && !we_i && (addr_i != 2'd0);
  end

  // Monitor: pops expectations whenever the DUT presents CPU read data or a UART access
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (rd_pend) begin
        if (exp_rd.size() == 0) fail_extra("cpu_read_extra", data_o);
        else check("cpu_read", data_o, exp_rd.pop_front());
      end
      if (u_sel_o && u_we_o) begin
        case (u_addr_o)
          2'd0: begin
            check("odr_while_busy", {31'd0, m_busy | force_busy}, 32'd0);
            if (exp_tx.size() == 0) fail_extra("odr_extra", u_data_o);
            else check("odr_byte", u_data_o, {24'd0, exp_tx.pop_front()});
          end
          2'd2: begin
            if (exp_bsr.size() == 0) fail_extra("bsr_extra", u_data_o);
            else begin
              check("bsr_value", u_data_o, {16'd0, exp_bsr.pop_front()});
              check("bsr_latency_over_3", 32'((cyc - last_wr_cyc) > 3), 32'd0);
            end
          end
          2'd3: begin
            check("clr_without_idr", {31'd0, idr_open}, 32'd1);
            idr_open <= 1'b0;
          end
          default: fail_extra("u_write_addr1", u_data_o);
        endcase
      end
      if (u_sel_o && !u_we_o && u_addr_o == 2'd1) begin
        check("idr_twice", {31'd0, idr_open}, 32'd0);
        idr_open <= 1'b1;
      end
    end
  end

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk_i);
    sel_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
    @(negedge clk_i);
    sel_i = 1'b0; we_i = 1'b0;
    last_wr_cyc = cyc;
  endtask

  task automatic cpu_read(input logic [1:0] a, input logic [31:0] e);
    exp_rd.push_back(e);
    @(negedge clk_i);
    sel_i = 1'b1; we_i = 1'b0; addr_i = a;
    @(negedge clk_i);
    sel_i = 1'b0;
  endtask

  task automatic wait_tx_drain(input int bound);
    int n = 0;
    while (exp_tx.size() != 0 && n < bound) begin @(negedge clk_i); n++; end
    check("tx_drain_timeout", 32'(exp_tx.size()), 32'd0);
  endtask

  task automatic wait_irq(input int bound);
    int n = 0;
    while (!irq_o && n < bound) begin @(negedge clk_i); n++; end
    check("irq_timeout", {31'd0, irq_o}, 32'd1);
  endtask

  task automatic wait_rx_delivered(input int bound);
    int n = 0;
    while ((rx_src.size() != 0 || m_rx) && n < bound) begin @(negedge clk_i); n++; end
    check("rx_deliver_timeout", 32'(rx_src.size() != 0 || m_rx), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int sr_n;
    int other_n;
    logic [7:0] b;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_data_o", data_o, 32'd0);
    check("rst_u_sel", {31'd0, u_sel_o}, 32'd0);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    rst_i = 1'b1;

    // Idle polling: exactly one SR read every 3 cycles, nothing else
    sr_n = 0; other_n = 0;
    repeat (12) begin
      @(negedge clk_i);
      if (u_sel_o) begin
        if (!u_we_o && u_addr_o == 2'd3) sr_n++;
        else other_n++;
      end
    end
    check("idle_sr_polls", 32'(sr_n), 32'd4);
    check("idle_other_access", 32'(other_n), 32'd0);
    cpu_read(2'd3, 32'h0000_0002);
    cpu_read(2'd2, 32'h0000_0002);

    // Transmit three bytes in order
    exp_tx.push_back(8'h55); cpu_write(2'd0, 32'h55);
    exp_tx.push_back(8'hA3); cpu_write(2'd0, 32'hA3);
    exp_tx.push_back(8'h0F); cpu_write(2'd0, 32'h0F);
    wait_tx_drain(500);
    repeat (40) @(negedge clk_i);
    cpu_read(2'd3, 32'h0000_0002);

    // Receive one byte
    rx_src.push_back({1'b0, 8'h3C});
    wait_irq(200);
    repeat (5) @(negedge clk_i);
    cpu_read(2'd3, 32'h0001_0006);
    cpu_read(2'd1, 32'h0000_003C);
    check("irq_after_pop", {31'd0, irq_o}, 32'd0);

    // Framing error byte
    rx_src.push_back({1'b1, 8'hA5});
    wait_irq(200);
    repeat (5) @(negedge clk_i);
    cpu_read(2'd1, 32'h0000_01A5);

    // TX overflow while the UART stays busy
    force_busy = 1'b1;
    repeat (6) @(negedge clk_i);
    for (int i = 0; i < 17; i++) begin
      b = 8'hC0 + 8'(i);
      if (i < 16) exp_tx.push_back(b);
      cpu_write(2'd0, {24'd0, b});
    end
    cpu_read(2'd3, 32'h0000_1061);
    cpu_write(2'd3, 32'h0000_0020);
    cpu_read(2'd3, 32'h0000_1041);
    force_busy = 1'b0;
    wait_tx_drain(2000);
    repeat (20) @(negedge clk_i);

    // RX overflow: 17 frames, no CPU reads
    for (int i = 0; i < 17; i++) rx_src.push_back({1'b0, 8'h10 + 8'(i)});
    wait_rx_delivered(1000);
    repeat (10) @(negedge clk_i);
    cpu_read(2'd3, 32'h0010_001E);
    for (int i = 0; i < 16; i++) cpu_read(2'd1, {24'd0, 8'h10 + 8'(i)});
    check("irq_rx_ovf", {31'd0, irq_o}, 32'd1);
    cpu_write(2'd3, 32'h0000_0010);
    cpu_read(2'd3, 32'h0000_0002);
    check("irq_cleared", {31'd0, irq_o}, 32'd0);

    // Baud write forwarded once
    exp_bsr.push_back(16'h01B0);
    cpu_write(2'd2, 32'h0000_01B0);
    repeat (10) @(negedge clk_i);
    cpu_read(2'd2, 32'h0000_01B0);

    repeat (10) @(negedge clk_i);
    check("left_cpu_reads", 32'(exp_rd.size()), 32'd0);
    check("left_tx_bytes", 32'(exp_tx.size()), 32'd0);
    check("left_bsr_writes", 32'(exp_bsr.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
